// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm system: the top-level state encoding
// (also decoded by the VGA display) and the countdown display limit.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMED     = 2'd1,
      TRIGGERED = 2'd2,
      ALERTING  = 2'd3
   } alarm_state_t;

   // Largest entry delay the two-digit seconds display can show.
   localparam int MAX_COUNTDOWN_S = 99;

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for an asynchronous board input, followed by a
// previous-value register so a held button yields a single-cycle rise.
module input_synchronizer (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic sync_1;
   logic sync_2;
   logic previous;

   // Metastability filter plus the history bit for edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         previous <= 1'b0;
      end else begin
         sync_1   <= raw;
         sync_2   <= sync_1;
         previous <= sync_2;
      end
   end

   assign level = sync_2;
   assign rise  = sync_2 & ~previous;

endmodule

// File: rtl/alarm_controller.sv
// Top-level alarm sequencer: synchronizes arm/disarm/sensor, runs the
// IDLE/ARMED/TRIGGERED/ALERTING state machine and the entry-delay countdown
// driven by a 1 Hz prescaler that only runs while TRIGGERED.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int CLOCK_HZ    = 50_000_000,
   parameter int COUNTDOWN_S = 30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       arm_request,
   input  logic       disarm_request,
   input  logic       sensor,
   output logic [1:0] system_state,
   output logic [7:0] timer,
   output logic       alarm
);

   // A 1-cycle prescaler would give a zero-width counter; keep at least one bit.
   localparam int PRESC_W = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_HZ - 1);

   // Entry delay clamped to what the two-digit display can show.
   localparam int LOAD_INT = (COUNTDOWN_S > MAX_COUNTDOWN_S) ? MAX_COUNTDOWN_S :
                             (COUNTDOWN_S < 1)               ? 1 : COUNTDOWN_S;
   localparam logic [7:0] LOAD_S = 8'(LOAD_INT);

   logic arm_rise;
   logic arm_level_unused;
   logic disarm_rise;
   logic disarm_level_unused;
   logic sensor_level;
   logic sensor_rise_unused;

   input_synchronizer u_arm_sync (
      .clock (clock),
      .reset (reset),
      .raw   (arm_request),
      .level (arm_level_unused),
      .rise  (arm_rise)
   );

   input_synchronizer u_disarm_sync (
      .clock (clock),
      .reset (reset),
      .raw   (disarm_request),
      .level (disarm_level_unused),
      .rise  (disarm_rise)
   );

   input_synchronizer u_sensor_sync (
      .clock (clock),
      .reset (reset),
      .raw   (sensor),
      .level (sensor_level),
      .rise  (sensor_rise_unused)
   );

   alarm_state_t       state_q;
   alarm_state_t       state_d;
   logic [7:0]         timer_q;
   logic [7:0]         timer_d;
   logic [PRESC_W-1:0] presc_q;
   logic [PRESC_W-1:0] presc_d;
   logic               alarm_q;
   logic               alarm_d;
   logic               tick;

   assign tick = (state_q == TRIGGERED) && (presc_q == PRESC_LAST);

   // State, countdown, prescaler and alarm registers; reset drops straight to IDLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= 8'd0;
         presc_q <= '0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         presc_q <= presc_d;
         alarm_q <= alarm_d;
      end
   end

   // Next state: disarm wins over tick/sensor, which win over arm.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      presc_d = '0;
      case (state_q)
         IDLE: begin
            timer_d = 8'd0;
            if (arm_rise) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            timer_d = 8'd0;
            if (disarm_rise) begin
               state_d = IDLE;
            end else if (sensor_level) begin
               state_d = TRIGGERED;
               timer_d = LOAD_S;
            end
         end
         TRIGGERED: begin
            if (disarm_rise) begin
               state_d = IDLE;
               timer_d = 8'd0;
            end else if (tick) begin
               // Last second (or an already-empty counter) expires into the alert.
               if (timer_q > 8'd1) begin
                  timer_d = timer_q - 8'd1;
               end else begin
                  timer_d = 8'd0;
                  state_d = ALERTING;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         ALERTING: begin
            timer_d = 8'd0;
            if (disarm_rise) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = 8'd0;
         end
      endcase
      alarm_d = (state_d == ALERTING);
   end

   assign system_state = state_q;
   assign timer        = timer_q;
   assign alarm        = alarm_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller at CLOCK_HZ = 10, COUNTDOWN_S = 3: a vector table
// for the arm/trigger path, hand-written corner sequences, and random traffic
// checked every cycle against a cycle-counting reference model.
module tb_alarm_controller;

   localparam int HZ = 10;
   localparam int CD = 3;

   logic       clock;
   logic       reset;
   logic       arm_request;
   logic       disarm_request;
   logic       sensor;
   logic [1:0] system_state;
   logic [7:0] timer;
   logic       alarm;

   int checks;
   int errors;

   alarm_controller #(.CLOCK_HZ(HZ), .COUNTDOWN_S(CD)) dut (
      .clock          (clock),
      .reset          (reset),
      .arm_request    (arm_request),
      .disarm_request (disarm_request),
      .sensor         (sensor),
      .system_state   (system_state),
      .timer          (timer),
      .alarm          (alarm)
   );

   // Clock generation.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   // Input histories: index 0 = sample at previous edge, 1 = two edges ago, ...
   bit ha[3];
   bit hd[3];
   bit hs[3];
   int m_state;
   int m_elapsed;

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         ha[i] = 1'b0;
         hd[i] = 1'b0;
         hs[i] = 1'b0;
      end
      m_state   = 0;
      m_elapsed = 0;
   endfunction

   function automatic int model_timer();
      if (m_state == 2) return CD - (m_elapsed / HZ);
      return 0;
   endfunction

   // An input seen at edge k acts at edge k+2; a request is a 0->1 step.
   function automatic void model_edge(input bit a, input bit d, input bit s);
      bit arm_e;
      bit dis_e;
      bit sen_l;
      arm_e = ha[1] && !ha[2];
      dis_e = hd[1] && !hd[2];
      sen_l = hs[1];
      case (m_state)
         0: if (arm_e) m_state = 1;
         1: begin
            if (dis_e) m_state = 0;
            else if (sen_l) begin
               m_state   = 2;
               m_elapsed = 0;
            end
         end
         2: begin
            if (dis_e) m_state = 0;
            else begin
               m_elapsed++;
               if (m_elapsed >= CD * HZ) m_state = 3;
            end
         end
         default: if (dis_e) m_state = 0;
      endcase
      ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = a;
      hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = d;
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = s;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare at negedge.
   task automatic cycle(input bit a, input bit d, input bit s);
      arm_request    = a;
      disarm_request = d;
      sensor         = s;
      @(posedge clock);
      if (!reset) model_reset();
      else model_edge(a, d, s);
      @(negedge clock);
      check("model_state", int'(system_state), m_state);
      check("model_timer", int'(timer), model_timer());
      check("model_alarm", int'(alarm), (m_state == 3) ? 1 : 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic arm_now();
      cycle(1'b1, 1'b0, 1'b0);
      idle_cycles(2);
      check("arm_now_state", int'(system_state), 1);
   endtask

   task automatic trigger_now();
      cycle(1'b0, 1'b0, 1'b1);
      idle_cycles(2);
      check("trig_entry_state", int'(system_state), 2);
      check("trig_entry_timer", int'(timer), CD);
   endtask

   task automatic disarm_now();
      cycle(1'b0, 1'b1, 1'b0);
      idle_cycles(3);
      check("disarm_state", int'(system_state), 0);
      check("disarm_timer", int'(timer), 0);
   endtask

   typedef struct {
      bit arm;
      bit dis;
      bit sen;
      int st;
      int tm;
      int al;
   } vec_t;

   vec_t tbl[6];

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1, 0, 0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1, 0, 0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1, 0, 0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 2, CD, 0};

      // Reset held with random inputs: everything stays cleared.
      reset          = 1'b0;
      arm_request    = 1'b0;
      disarm_request = 1'b0;
      sensor         = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("reset_state", int'(system_state), 0);
         check("reset_timer", int'(timer), 0);
         check("reset_alarm", int'(alarm), 0);
      end
      reset = 1'b1;
      idle_cycles(5);
      check("post_reset_state", int'(system_state), 0);

      // Arm and trigger from the vector table.
      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].arm, tbl[i].dis, tbl[i].sen);
         check("tbl_state", int'(system_state), tbl[i].st);
         check("tbl_timer", int'(timer), tbl[i].tm);
         check("tbl_alarm", int'(alarm), tbl[i].al);
      end

      // Countdown: 3 -> 2 -> 1 at +10/+20, alert at +30.
      for (int n = 1; n <= CD * HZ; n++) begin
         cycle(1'b0, 1'b0, 1'b0);
         check("cd_timer", int'(timer), (n < CD * HZ) ? CD - n / HZ : 0);
         check("cd_state", int'(system_state), (n < CD * HZ) ? 2 : 3);
         check("cd_alarm", int'(alarm), (n < CD * HZ) ? 0 : 1);
      end
      idle_cycles(5);
      check("alert_hold_timer", int'(timer), 0);
      disarm_now();
      check("alert_disarm_alarm", int'(alarm), 0);

      // Disarm mid-countdown while timer = 2, then a sensor pulse is ignored.
      arm_now();
      trigger_now();
      idle_cycles(HZ);
      check("mid_timer_two", int'(timer), 2);
      cycle(1'b0, 1'b1, 1'b0);
      idle_cycles(2);
      check("mid_disarm_state", int'(system_state), 0);
      check("mid_disarm_timer", int'(timer), 0);
      cycle(1'b0, 1'b0, 1'b1);
      idle_cycles(6);
      check("mid_sensor_ignored", int'(system_state), 0);

      // Disarm edge lands in the same cycle as the final tick.
      arm_now();
      trigger_now();
      for (int n = 1; n <= 40; n++) begin
         cycle(1'b0, (n == 28 || n == 29) ? 1'b1 : 1'b0, 1'b0);
         check("simul_alarm", int'(alarm), 0);
         if (n == 29) check("simul_timer_before", int'(timer), 1);
      end
      check("simul_state", int'(system_state), 0);

      // Held arm: one arming only; no re-arm until released and pressed again.
      for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 1'b0);
      check("held_armed", int'(system_state), 1);
      cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);
      check("held_no_rearm", int'(system_state), 0);
      idle_cycles(3);
      check("released_idle", int'(system_state), 0);
      arm_now();
      disarm_now();

      // Ignored events: arm in ARMED/TRIGGERED, sensor in IDLE.
      arm_now();
      cycle(1'b1, 1'b0, 1'b0);
      idle_cycles(3);
      check("arm_in_armed", int'(system_state), 1);
      trigger_now();
      cycle(1'b1, 1'b0, 1'b0);
      idle_cycles(3);
      check("arm_in_trig_state", int'(system_state), 2);
      check("arm_in_trig_timer", int'(timer), CD);
      disarm_now();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
      idle_cycles(3);
      check("sensor_in_idle", int'(system_state), 0);

      // Reset asserted during ALERTING clears at once, without waiting for an edge.
      arm_now();
      trigger_now();
      idle_cycles(CD * HZ);
      check("pre_reset_alarm", int'(alarm), 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_state", int'(system_state), 0);
      check("async_reset_timer", int'(timer), 0);
      check("async_reset_alarm", int'(alarm), 0);
      model_reset();
      @(negedge clock);
      idle_cycles(2);
      reset = 1'b1;
      idle_cycles(4);
      check("after_reset_idle", int'(system_state), 0);

      // Random traffic against the reference model, with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 799) == 0) begin
            reset = 1'b0;
            cycle(1'b0, 1'b0, 1'b0);
            reset = 1'b1;
         end else begin
            cycle(($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 7) == 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
